// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the instruction fetch stage.
//   fetchState_e : fetch FSM states
//   CAUSE_*      : fault cause codes presented on if_cause
//   NOP_INSTR    : instruction word presented alongside any fault
package fetch_pkg;
   typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN} fetchState_e;
   localparam logic [1:0] CAUSE_NONE     = 2'b00;
   localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
   localparam logic [1:0] CAUSE_BUSERR   = 2'b10;
   localparam logic [1:0] CAUSE_TIMEOUT  = 2'b11;
   localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
endpackage

// File: rtl/fetch_timeout_counter.sv
// fetch_timeout_counter: counts cycles spent waiting on memory and flags expiry.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the count (takes priority over en)
//   en       : advance the count by one
//   expired  : count has reached LIMIT-1
module fetch_timeout_counter #(
   parameter int WIDTH = 4,
   parameter int LIMIT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired
);
   logic [WIDTH-1:0] count;

   always_ff @(posedge clk or posedge rst)
      if (rst) count <= '0;
      else if (clr) count <= '0;
      else if (en) count <= count + 1'b1;

   assign expired = count == WIDTH'(LIMIT - 1);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches the word at the current PC and hands it to decode.
//   pc_in / pc_load / pc_next      : PC register interface (PC+4 on consume, target on redirect)
//   redirect_valid / redirect_pc   : branch/jump/trap redirect request
//   imem_req/addr/gnt/rvalid/rdata/err : single-outstanding instruction memory port
//   if_valid/ready/instr/pc/fault/cause : decode handshake and fetched instruction
module instr_fetch_unit import fetch_pkg::*; #(
   parameter int XLEN = 32,
   parameter int TIMEOUT_CYCLES = 16,
   parameter logic [XLEN-1:0] NOP_INSTR = XLEN'(fetch_pkg::NOP_INSTR)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc_in,
   output logic            pc_load,
   output logic [XLEN-1:0] pc_next,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_err,
   output logic            if_valid,
   input  logic            if_ready,
   output logic [XLEN-1:0] if_instr,
   output logic [XLEN-1:0] if_pc,
   output logic            if_fault,
   output logic [1:0]      if_cause
);
   fetchState_e state, stateNext;
   logic [XLEN-1:0] instrQ, instrNext, pcQ, pcCap;
   logic faultQ, faultNext;
   logic [1:0] causeQ, causeNext;
   logic misaligned, redirect, consume, expired;

   assign misaligned = |pc_in[1:0];
   assign redirect   = redirect_valid && state != IDLE;
   assign consume    = state == HOLD && if_ready;
   assign imem_req   = state == REQ && !misaligned;
   assign imem_addr  = imem_req ? pc_in : '0;
   assign pc_load    = redirect || consume;
   assign pc_next    = redirect ? redirect_pc : consume ? pc_in + XLEN'(4) : '0;
   assign if_valid   = state == HOLD;
   assign if_instr   = instrQ;
   assign if_pc      = pcQ;
   assign if_fault   = faultQ;
   assign if_cause   = causeQ;

   fetch_timeout_counter #(
      .WIDTH($clog2(TIMEOUT_CYCLES)),
      .LIMIT(TIMEOUT_CYCLES)
   ) timeoutCounter (
      .clk(clk),
      .rst(rst),
      .clr(state == REQ && imem_gnt),
      .en(state == WAIT),
      .expired(expired)
   );

   // Redirect always wins; a response arriving with a redirect is dropped,
   // otherwise the in-flight response must be drained before the next request.
   always_comb begin
      stateNext = state;
      instrNext = instrQ;
      pcCap     = pcQ;
      faultNext = faultQ;
      causeNext = causeQ;
      case (state)
         IDLE: stateNext = REQ;
         REQ:
            if (redirect) stateNext = REQ;
            else if (misaligned) begin
               stateNext = HOLD;
               pcCap     = pc_in;
               instrNext = NOP_INSTR;
               faultNext = 1'b1;
               causeNext = CAUSE_MISALIGN;
            end
            else if (imem_gnt) stateNext = WAIT;
         WAIT:
            if (redirect) stateNext = imem_rvalid ? REQ : DRAIN;
            else if (imem_rvalid || expired) begin
               stateNext = HOLD;
               pcCap     = pc_in;
               instrNext = imem_rvalid && !imem_err ? imem_rdata : NOP_INSTR;
               faultNext = !imem_rvalid || imem_err;
               causeNext = !imem_rvalid ? CAUSE_TIMEOUT : imem_err ? CAUSE_BUSERR : CAUSE_NONE;
            end
         HOLD:
            if (redirect || if_ready) begin
               stateNext = REQ;
               faultNext = 1'b0;
               causeNext = CAUSE_NONE;
            end
         DRAIN: stateNext = imem_rvalid ? REQ : DRAIN;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state  <= IDLE;
         instrQ <= NOP_INSTR;
         pcQ    <= '0;
         faultQ <= 1'b0;
         causeQ <= CAUSE_NONE;
      end
      else begin
         state  <= stateNext;
         instrQ <= instrNext;
         pcQ    <= pcCap;
         faultQ <= faultNext;
         causeQ <= causeNext;
      end
endmodule
